mem_bus_arbiter: RTL and testbench

- Shares the single memory bus between two requesters: port 0 is instruction fetch, port 1 is load/store.
- Each requester uses a valid/ready request channel and an rvalid read-response channel.
- Drives the memory-side write and read strobes, addresses and write data, and returns read data after a fixed memory read latency.
- Sits between the core's fetch/LSU units and the memory attached to the bus.

---
 rtl/mem_bus_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter for a single memory bus: port 0 = instruction fetch,
// port 1 = load/store. One transaction in flight; reads return after RD_LATENCY + 2 cycles.
module mem_bus_arbiter #(
  parameter int unsigned RD_LATENCY = 1  // legal 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_rvalid,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_rvalid,
  output logic [31:0] req1_rdata,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        mem_rd_en,
  output logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  output logic        busy
);

  // Handshake: a request transfers on a rising edge where valid && ready; ready is only
  // offered in IDLE and only to the granted port, so at most one transfer per edge.

  localparam logic [3:0] LAT = 4'(RD_LATENCY);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_RESP  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic        any_valid;
  logic        grant_port;
  logic        accept;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;

  // Tie goes to the port that did not win last time; a lone requester always wins.
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    grant_port = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    accept     = rst && (state_q == IDLE) && any_valid;
    req0_ready = accept && !grant_port;
    req1_ready = accept && grant_port;
    sel_we     = grant_port ? req1_we    : req0_we;
    sel_addr   = grant_port ? req1_addr  : req0_addr;
    sel_wdata  = grant_port ? req1_wdata : req0_wdata;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_addr_d    = rd_addr_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          owner_d      = grant_port;
          last_grant_d = grant_port;
          if (sel_we) begin
            wr_addr_d = sel_addr;
            wr_data_d = sel_wdata;
            state_d   = WRITE;
          end else begin
            rd_addr_d = sel_addr;
            state_d   = RD_ISSUE;
          end
        end
      end
      WRITE: state_d = IDLE;
      RD_ISSUE: begin
        cnt_d   = LAT;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Counter reaches 1 in the cycle the memory presents the data.
        if (cnt_q == 4'd1) begin
          if (owner_q) rdata1_d = mem_rd_data;
          else         rdata0_d = mem_rd_data;
          state_d = RD_RESP;
        end
      end
      RD_RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= 4'd0;
      wr_addr_q    <= 32'd0;
      wr_data_q    <= 32'd0;
      rd_addr_q    <= 32'd0;
      rdata0_q     <= 32'd0;
      rdata1_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_addr_q    <= rd_addr_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  always_comb begin
    mem_wr_en   = (state_q == WRITE);
    mem_rd_en   = (state_q == RD_ISSUE);
    mem_wr_addr = wr_addr_q;
    mem_wr_data = wr_data_q;
    mem_rd_addr = rd_addr_q;
    req0_rvalid = (state_q == RD_RESP) && !owner_q;
    req1_rvalid = (state_q == RD_RESP) && owner_q;
    req0_rdata  = rdata0_q;
    req1_rdata  = rdata1_q;
    busy        = (state_q != IDLE);
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: transaction-level timing model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_mem_bus_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_ready, req0_rvalid, req1_ready, req1_rvalid;
  logic [31:0] req0_rdata, req1_rdata;
  logic        mem_wr_en, mem_rd_en, busy;
  logic [31:0] mem_wr_addr, mem_wr_data, mem_rd_addr, mem_rd_data;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.RD_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h200) return 32'h1234_5678;
    return (a * 32'd3) ^ 32'h0F0F_1111;
  endfunction

  // Memory: data for a read strobed in cycle C is presented during cycle C+L, garbage otherwise.
  logic        pv[L];
  logic [31:0] pa[L];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < L; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= mem_rd_en;
      pa[0] <= mem_rd_addr;
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end
  logic [31:0] garbage;
  assign garbage     = 32'hDEAD_0000 | 32'(cyc[15:0]);
  assign mem_rd_data = (pv[L-1] === 1'b1) ? mem_val(pa[L-1]) : garbage;

  // Transaction-level model: one pending transaction with its accept cycle.
  logic        m_active = 1'b0, m_we = 1'b0, m_port = 1'b0, m_last = 1'b1;
  int          m_start = 0, m_free = 0;
  logic [31:0] m_addr = '0, m_data = '0;
  logic [31:0] m_wr_addr = '0, m_wr_data = '0, m_rd_addr = '0, m_rdata0 = '0, m_rdata1 = '0;
  logic [31:0] wr_log[$];
  int          wr_cyc[$];
  int          strobe_cnt = 0;

  always @(negedge clk) begin
    logic e_wr, e_rd, e_resp, g0, g1, e_rdy0, e_rdy1;
    if (!rst) begin
      chk("rst_ready0", req0_ready, 0);   chk("rst_ready1", req1_ready, 0);
      chk("rst_rvalid0", req0_rvalid, 0); chk("rst_rvalid1", req1_rvalid, 0);
      chk("rst_rdata0", req0_rdata, 0);   chk("rst_rdata1", req1_rdata, 0);
      chk("rst_wr_en", mem_wr_en, 0);     chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_wr_addr", mem_wr_addr, 0); chk("rst_wr_data", mem_wr_data, 0);
      chk("rst_rd_addr", mem_rd_addr, 0); chk("rst_busy", busy, 0);
      m_active = 0; m_last = 1; m_wr_addr = 0; m_wr_data = 0; m_rd_addr = 0;
      m_rdata0 = 0; m_rdata1 = 0;
    end else begin
      if (m_active && cyc >= m_free) m_active = 0;
      e_wr   = m_active && m_we && (cyc == m_start + 1);
      e_rd   = m_active && !m_we && (cyc == m_start + 1);
      e_resp = m_active && !m_we && (cyc == m_start + L + 2);
      if (e_wr) begin m_wr_addr = m_addr; m_wr_data = m_data; end
      if (e_rd) m_rd_addr = m_addr;
      if (e_resp) begin
        if (m_port) m_rdata1 = mem_val(m_addr);
        else        m_rdata0 = mem_val(m_addr);
      end
      g0 = req0_valid && (!req1_valid || m_last == 1'b1);
      g1 = req1_valid && (!req0_valid || m_last == 1'b0);
      e_rdy0 = !m_active && g0;
      e_rdy1 = !m_active && g1;
      chk("ready0", req0_ready, e_rdy0);  chk("ready1", req1_ready, e_rdy1);
      chk("rvalid0", req0_rvalid, e_resp && !m_port);
      chk("rvalid1", req1_rvalid, e_resp && m_port);
      chk("rdata0", req0_rdata, m_rdata0); chk("rdata1", req1_rdata, m_rdata1);
      chk("wr_en", mem_wr_en, e_wr);       chk("rd_en", mem_rd_en, e_rd);
      chk("wr_addr", mem_wr_addr, m_wr_addr); chk("wr_data", mem_wr_data, m_wr_data);
      chk("rd_addr", mem_rd_addr, m_rd_addr); chk("busy", busy, m_active);
      if (e_rdy0 || e_rdy1) begin
        m_active = 1; m_start = cyc; m_port = e_rdy1;
        m_we   = e_rdy1 ? req1_we : req0_we;
        m_addr = e_rdy1 ? req1_addr : req0_addr;
        m_data = e_rdy1 ? req1_wdata : req0_wdata;
        m_free = m_we ? cyc + 2 : cyc + L + 3;
        m_last = e_rdy1;
      end
    end
    if (mem_wr_en === 1'b1) begin wr_log.push_back(mem_wr_addr); wr_cyc.push_back(cyc); end
    if (mem_wr_en === 1'b1 || mem_rd_en === 1'b1 || req0_rvalid === 1'b1 || req1_rvalid === 1'b1)
      strobe_cnt++;
    cyc++;
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic drive(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    logic rdy;
    bit   done;
    done = 0;
    if (p == 0) begin req0_valid = 1; req0_we = we; req0_addr = a; req0_wdata = d; end
    else        begin req1_valid = 1; req1_we = we; req1_addr = a; req1_wdata = d; end
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      rdy = (p == 0) ? req0_ready : req1_ready;
      @(posedge clk); #1;
      done = (rdy === 1'b1);
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL accept_timeout: port %0d got no ready, expected accept within 100 cycles", p);
    end
    if (p == 0) begin req0_valid = 0; req0_we = 1'($urandom_range(0, 1)); req0_addr = $urandom; req0_wdata = $urandom; end
    else        begin req1_valid = 0; req1_we = 1'($urandom_range(0, 1)); req1_addr = $urandom; req1_wdata = $urandom; end
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: got timeout, expected bench to finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_rr[6];
    exp_rr = '{32'h1000, 32'h2000, 32'h1004, 32'h2004, 32'h1008, 32'h2008};
    rst = 0;
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;

    // Reset with random inputs, then both valid on release: port 0 wins the first tie.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req0_valid = 1'($urandom_range(0, 1)); req0_we = 1'($urandom_range(0, 1));
      req0_addr = $urandom; req0_wdata = $urandom;
      req1_valid = 1'($urandom_range(0, 1)); req1_we = 1'($urandom_range(0, 1));
      req1_addr = $urandom; req1_wdata = $urandom;
    end
    @(posedge clk); #1;
    req0_valid = 1; req1_valid = 1;
    @(negedge clk);
    chk("rst_both_valid_ready0", req0_ready, 0);
    @(posedge clk); #1;
    rst = 1;
    fork
      drive(0, 1, 32'h10, 32'hA);
      drive(1, 1, 32'h14, 32'hB);
      begin
        @(negedge clk);
        chk("first_tie_ready0", req0_ready, 1);
        chk("first_tie_ready1", req1_ready, 0);
      end
    join

    // Write: strobe in the cycle after accept, back to IDLE one cycle later.
    drive(0, 1, 32'h100, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("write_wr_en", mem_wr_en, 1);
    chk("write_wr_addr", mem_wr_addr, 32'h100);
    chk("write_wr_data", mem_wr_data, 32'hDEAD_BEEF);
    chk("write_rd_en", mem_rd_en, 0);
    @(negedge clk);
    chk("write_idle_busy", busy, 0);

    // Read on port 1: rd_en one cycle after accept, rvalid L+2 cycles after accept.
    @(posedge clk); #1;
    drive(1, 0, 32'h200, 32'h0);
    @(negedge clk);
    chk("read_rd_en", mem_rd_en, 1);
    chk("read_rd_addr", mem_rd_addr, 32'h200);
    chk("read_wr_en", mem_wr_en, 0);
    repeat (L + 1) @(posedge clk);
    @(negedge clk);
    chk("read_rvalid1", req1_rvalid, 1);
    chk("read_rdata1", req1_rdata, 32'h1234_5678);
    chk("read_rvalid0", req0_rvalid, 0);

    // Round-robin: both ports keep valid high with back-to-back writes.
    @(posedge clk); #1;
    wr_log.delete(); wr_cyc.delete();
    fork
      for (int i = 0; i < 3; i++) drive(0, 1, 32'h1000 + 32'(4 * i), 32'hC000 + 32'(i));
      for (int i = 0; i < 3; i++) drive(1, 1, 32'h2000 + 32'(4 * i), 32'hD000 + 32'(i));
    join
    repeat (2) @(posedge clk);
    chk("rr_count", 32'(wr_log.size()), 6);
    for (int i = 0; i < 6 && i < wr_log.size(); i++) begin
      chk("rr_order", wr_log[i], exp_rr[i]);
      if (i > 0) chk("rr_spacing", 32'(wr_cyc[i] - wr_cyc[i-1]), 2);
    end

    // Back-pressure: port 0 waits through port 1's read, accepted in the first IDLE cycle.
    #1;
    drive(1, 0, 32'h300, 32'h0);
    @(posedge clk); #1;
    fork
      drive(0, 1, 32'h400, 32'h55AA_55AA);
      begin
        for (int i = 0; i < L + 1; i++) begin
          @(negedge clk);
          chk("bp_ready0_busy", req0_ready, 0);
        end
        @(negedge clk);
        chk("bp_ready0_idle", req0_ready, 1);
      end
    join
    @(negedge clk);
    chk("bp_wr_addr", mem_wr_addr, 32'h400);
    chk("bp_rdata1", req1_rdata, mem_val(32'h300));

    // Reset during RD_WAIT: outputs clear at once, nothing follows release.
    @(posedge clk); #1;
    drive(1, 0, 32'h500, 32'h0);
    @(posedge clk); #1;
    chk("midrd_busy_before", busy, 1);
    rst = 0;
    #1;
    chk("midrd_busy", busy, 0);
    chk("midrd_rd_addr", mem_rd_addr, 0);
    chk("midrd_wr_addr", mem_wr_addr, 0);
    chk("midrd_wr_data", mem_wr_data, 0);
    chk("midrd_rdata1", req1_rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    strobe_cnt = 0;
    repeat (8) @(negedge clk);
    chk("midrd_no_strobes", 32'(strobe_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
